uart_tx_buffer: RTL and testbench
=================================

Name: uart_tx_buffer

Overview:
Transmit-side companion to the UART receive buffer. The CPU fills a small byte array by address and then writes a start command to a control address. The block then hands the bytes, in order from entry 0, to the UART transmitter through a start/done handshake. A read-back busy bit and a one-cycle completion pulse let the CPU know when the array can be refilled.

Parameters:
DEPTH, 5, number of data bytes per frame; the control/status register sits at address DEPTH
DATA_W, 8, byte width
ADDR_W, 3, CPU address width; must satisfy 2^ADDR_W > DEPTH

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wr  in  1  CPU write strobe, one write per cycle while high
address  in  ADDR_W  CPU address for read and write
w_data  in  DATA_W  CPU write data
r_data  out  DATA_W  CPU read data, combinational from address
tx_busy  in  1  high while the UART transmitter is shifting a byte
tx_done  in  1  one-cycle pulse from the transmitter when the stop bit ends
tx_data  out  DATA_W  byte presented to the transmitter, registered
tx_start  out  1  one-cycle request to the transmitter, registered
busy  out  1  high from the accepted start until the last tx_done
done  out  1  one-cycle pulse on completion of the last byte

Behaviour:
- Reset (rst_n=0, asynchronous): all buffer entries = 0; tx_data = 0; tx_start = 0; busy = 0; done = 0; rd_ptr = 0; state = IDLE. Reset asserted mid-frame aborts the frame immediately, with no done pulse.
- Storage: DEPTH x DATA_W registers. rd_ptr is wide enough for 0..DEPTH-1.
- CPU write, address < DEPTH, busy=0: the entry is updated at the clock edge.
- CPU write, address < DEPTH, busy=1: the write is ignored and the buffer stays frozen during transmission.
- CPU write, address == DEPTH, w_data[0]=1, busy=0: start is accepted; busy=1 after that edge. Other w_data bits are ignored.
- Start written while busy=1 is ignored. Writes to addresses > DEPTH are ignored.
- CPU read, address < DEPTH: r_data = entry.
- CPU read, address == DEPTH: r_data = {zeros, busy}.
- CPU read, address > DEPTH: r_data = 0.
- FSM state IDLE: busy=0. On an accepted start: rd_ptr <= 0, go to LOAD.
- FSM state LOAD: if tx_busy=0, drive tx_data <= buf[rd_ptr] and tx_start <= 1 for exactly one cycle, then go to WAIT. If tx_busy=1, stay in LOAD with tx_start=0.
- FSM state WAIT: hold tx_data. On tx_done=1 with rd_ptr == DEPTH-1: go to IDLE, busy <= 0, done <= 1 for one cycle.
- FSM state WAIT: on tx_done=1 with rd_ptr < DEPTH-1: rd_ptr <= rd_ptr+1, go to LOAD.
- tx_done in any state other than WAIT is ignored.
- Latency: start write at edge N gives busy=1 after N. With tx_busy=0, tx_start=1 and tx_data=buf[0] after edge N+1. After tx_done at edge M, the next tx_start follows M+1.
- Simultaneous final tx_done and a CPU data write: busy is still 1 in that cycle, so the write is dropped.
- Simultaneous final tx_done and a start write: the start is dropped; the CPU must see busy=0 first.
- tx_data keeps the last byte sent after completion; it changes only in LOAD.
- No overflow or wrap: a frame is always exactly DEPTH bytes. rd_ptr returns to 0 only on the next accepted start.

Test Plan:
- Reset then read all addresses: r_data=0 at 0..5 and at 6,7; tx_start=0, busy=0, done=0.
- Write 0x11,0x22,0x33,0x44,0x55 to addr 0..4, then 0x01 to addr 5; transmitter model returns tx_done 10 cycles after each tx_start. Required: exactly five tx_start pulses carrying 0x11..0x55 in order; busy=1 throughout; one done pulse after the 5th tx_done; addr 5 then reads 0x00.
- During transmission write 0xAA to addr 2 and 0x01 to addr 5: addr 2 still reads 0x33; still exactly five bytes sent; no second frame.
- Hold tx_busy=1 for 7 cycles after start: tx_start stays 0; it pulses on the first cycle after tx_busy falls, with tx_data=0x11.
- Stray tx_done pulses in IDLE and in LOAD: no state change, rd_ptr unchanged, no done pulse.
- Assert rst_n=0 after the 2nd byte's tx_start: all outputs and buffer entries go to 0 immediately. Restart after refill sends from entry 0.

Source files
------------

// File: rtl/uart_tx_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buffer_if
// Brief    : CPU register-port and transmitter handshake bundle for uart_tx_buffer
// Revision : 1.0
// ============================================================================
interface uart_tx_buffer_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              wr;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] r_data;
    logic              tx_busy;
    logic              tx_done;
    logic [DATA_W-1:0] tx_data;
    logic              tx_start;
    logic              busy;
    logic              done;

    modport slave (
        input  wr, address, w_data, tx_busy, tx_done,
        output r_data, tx_data, tx_start, busy, done
    );

    modport master (
        output wr, address, w_data, tx_busy, tx_done,
        input  r_data, tx_data, tx_start, busy, done
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buffer
// Brief    : CPU-filled byte frame streamed in order to a UART transmitter
// Revision : 1.0
// ============================================================================
module uart_tx_buffer #(
    parameter int DEPTH  = 5,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    uart_tx_buffer_if.slave  bus
);
    localparam int                PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W-1:0] CTRL_ADDR = ADDR_W'(DEPTH);
    localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   buf_q [DEPTH];

    logic                busy_w;
    logic [PTR_W-1:0]    addr_idx;
    logic                data_wr;
    logic                start_acc;

    // Busy is exactly "frame in flight", so it tracks the non-idle states.
    assign busy_w    = (state_q != S_IDLE);
    assign addr_idx  = bus.address[PTR_W-1:0];
    assign data_wr   = bus.wr && (bus.address < CTRL_ADDR) && !busy_w;
    assign start_acc = bus.wr && (bus.address == CTRL_ADDR) && bus.w_data[0] && !busy_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
        end else if (data_wr) begin
            buf_q[addr_idx] <= bus.w_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            rd_ptr_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rd_ptr_d   = rd_ptr_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_acc) begin
                    rd_ptr_d = '0;
                    state_d  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (!bus.tx_busy) begin
                    tx_data_d  = buf_q[rd_ptr_q];
                    tx_start_d = 1'b1;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.tx_done) begin
                    if (rd_ptr_q == LAST_PTR) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                        state_d  = S_LOAD;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.r_data = '0;
        if (bus.address < CTRL_ADDR) begin
            bus.r_data = buf_q[addr_idx];
        end else if (bus.address == CTRL_ADDR) begin
            bus.r_data = DATA_W'(busy_w);
        end
    end

    assign bus.tx_data  = tx_data_q;
    assign bus.tx_start = tx_start_q;
    assign bus.busy     = busy_w;
    assign bus.done     = done_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_buffer
// Brief    : Randomized self-checking bench with a frame-level reference model
// Revision : 1.0
// ============================================================================
module tb_uart_tx_buffer;
    localparam int DEPTH  = 5;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    uart_tx_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    uart_tx_buffer #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: CPU-visible array, snapshot of the frame being sent
    logic [7:0] ref_buf   [DEPTH];
    logic [7:0] ref_frame [DEPTH];
    bit         ref_busy    = 1'b0;
    int         ref_sent    = 0;
    bit         outstanding = 1'b0;

    logic [7:0] obs [$];
    int         done_cnt  = 0;
    int         busy_err  = 0;
    int         tx_cnt    = 0;
    int         tx_lat    = 10;
    bit         stray_req = 1'b0;

    // Model of CPU-visible effects, evaluated on the same edges as the DUT
    initial forever begin
        bit was_busy;
        @(posedge clk);
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ref_buf[i] = 8'h00;
            ref_busy    = 1'b0;
            ref_sent    = 0;
            outstanding = 1'b0;
        end else begin
            was_busy = ref_busy;
            if (bus.wr && !was_busy) begin
                if (int'(bus.address) < DEPTH) begin
                    ref_buf[int'(bus.address)] = bus.w_data;
                end else if (int'(bus.address) == DEPTH && bus.w_data[0]) begin
                    ref_busy  = 1'b1;
                    ref_sent  = 0;
                    ref_frame = ref_buf;
                end
            end
            if (bus.tx_done && outstanding) begin
                outstanding = 1'b0;
                ref_sent++;
                if (ref_sent == DEPTH) ref_busy = 1'b0;
            end
        end
    end

    // Transmitter model plus output monitor
    initial begin
        bus.tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.tx_done = 1'b0;
                tx_cnt      = 0;
            end else begin
                bus.tx_done = stray_req;
                if (tx_cnt > 0) begin
                    tx_cnt--;
                    if (tx_cnt == 0) bus.tx_done = 1'b1;
                end
                if (bus.tx_start) begin
                    obs.push_back(bus.tx_data);
                    outstanding = 1'b1;
                    tx_cnt      = tx_lat;
                end
                if (bus.done) done_cnt++;
                if (ref_busy !== bus.busy) busy_err++;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic cpu_write(input int a, input logic [7:0] d);
        bus.wr      = 1'b1;
        bus.address = 3'(a);
        bus.w_data  = d;
        @(negedge clk);
        #1;
        bus.wr = 1'b0;
    endtask

    task automatic rd(input int a, output logic [7:0] d);
        bus.address = 3'(a);
        #1;
        d = bus.r_data;
    endtask

    task automatic fill_seq();
        for (int i = 0; i < DEPTH; i++) cpu_write(i, 8'(17 * (i + 1)));
    endtask

    task automatic fill_random();
        for (int i = 0; i < DEPTH; i++) cpu_write(i, 8'($urandom_range(0, 255)));
    endtask

    task automatic start_frame();
        cpu_write(DEPTH, 8'($urandom_range(0, 255)) | 8'h01);
    endtask

    task automatic wait_done(input int base, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if (done_cnt > base) begin
                ok = 1'b1;
                break;
            end
            cycles(1);
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        #2;
        n_cmp++; if (bus.tx_start !== 1'b0) begin n_err++; $display("FAIL reset_tx_start: got %b want 0", bus.tx_start); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if (bus.done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.done); end
        n_cmp++; if (bus.tx_data !== 8'h00) begin n_err++; $display("FAIL reset_tx_data: got %h want 00", bus.tx_data); end
        for (int a = 0; a < 8; a++) begin
            cycles(1);
            rd(a, d);
            n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL reset_read[%0d]: got %h want 00", a, d); end
        end
        cycles(1);
        rst_n = 1'b1;
        cycles(2);
    endtask

    task automatic test_frame();
        bit ok;
        int base;
        logic [7:0] d;
        for (int f = 0; f < 3; f++) begin
            obs.delete();
            base = done_cnt;
            if (f == 0) fill_seq(); else fill_random();
            start_frame();
            n_cmp++; if (bus.busy !== 1'b1) begin n_err++; $display("FAIL frame_busy_after_start: got %b want 1", bus.busy); end
            wait_done(base, ok);
            n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL frame_timeout: got %b want 1", ok); end
            n_cmp++; if (obs.size() !== DEPTH) begin n_err++; $display("FAIL frame_count: got %0d want %0d", obs.size(), DEPTH); end
            for (int i = 0; i < DEPTH && i < obs.size(); i++) begin
                n_cmp++; if (obs[i] !== ref_frame[i]) begin n_err++; $display("FAIL frame_byte[%0d]: got %h want %h", i, obs[i], ref_frame[i]); end
            end
            if (f == 0) begin
                for (int i = 0; i < DEPTH && i < obs.size(); i++) begin
                    n_cmp++; if (obs[i] !== 8'(17 * (i + 1))) begin n_err++; $display("FAIL frame_fixed[%0d]: got %h want %h", i, obs[i], 8'(17 * (i + 1))); end
                end
            end
            cycles(3);
            n_cmp++; if (done_cnt - base !== 1) begin n_err++; $display("FAIL frame_done_pulses: got %0d want 1", done_cnt - base); end
            n_cmp++; if (bus.tx_data !== ref_frame[DEPTH-1]) begin n_err++; $display("FAIL frame_tx_data_hold: got %h want %h", bus.tx_data, ref_frame[DEPTH-1]); end
            rd(DEPTH, d);
            n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL frame_status_idle: got %h want 00", d); end
            cycles(1);
        end
    endtask

    task automatic test_frozen();
        bit ok;
        int base;
        logic [7:0] d, keep;
        obs.delete();
        base = done_cnt;
        fill_random();
        keep = ref_buf[2];
        start_frame();
        for (int i = 0; i < 100 && obs.size() < 1; i++) cycles(1);
        rd(DEPTH, d);
        n_cmp++; if (d !== 8'h01) begin n_err++; $display("FAIL frozen_status_busy: got %h want 01", d); end
        cpu_write(2, 8'hAA);
        cpu_write(DEPTH, 8'h01);
        wait_done(base, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL frozen_timeout: got %b want 1", ok); end
        rd(2, d);
        n_cmp++; if (d !== keep) begin n_err++; $display("FAIL frozen_entry2: got %h want %h", d, keep); end
        cycles(30);
        n_cmp++; if (obs.size() !== DEPTH) begin n_err++; $display("FAIL frozen_count: got %0d want %0d", obs.size(), DEPTH); end
        for (int i = 0; i < DEPTH && i < obs.size(); i++) begin
            n_cmp++; if (obs[i] !== ref_frame[i]) begin n_err++; $display("FAIL frozen_byte[%0d]: got %h want %h", i, obs[i], ref_frame[i]); end
        end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL frozen_no_second_frame: got %b want 0", bus.busy); end
    endtask

    task automatic test_tx_busy_hold();
        bit ok;
        int base;
        obs.delete();
        base = done_cnt;
        fill_seq();
        bus.tx_busy = 1'b1;
        start_frame();
        cycles(7);
        n_cmp++; if (obs.size() !== 0) begin n_err++; $display("FAIL hold_no_start: got %0d want 0", obs.size()); end
        bus.tx_busy = 1'b0;
        cycles(1);
        n_cmp++; if (bus.tx_start !== 1'b1) begin n_err++; $display("FAIL hold_start_after_release: got %b want 1", bus.tx_start); end
        n_cmp++; if (bus.tx_data !== 8'h11) begin n_err++; $display("FAIL hold_first_byte: got %h want 11", bus.tx_data); end
        wait_done(base, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL hold_timeout: got %b want 1", ok); end
        n_cmp++; if (obs.size() !== DEPTH) begin n_err++; $display("FAIL hold_count: got %0d want %0d", obs.size(), DEPTH); end
        cycles(2);
    endtask

    task automatic test_stray_done();
        bit ok;
        int base;
        obs.delete();
        base = done_cnt;
        stray_req = 1'b1;
        cycles(1);
        stray_req = 1'b0;
        cycles(3);
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL stray_idle_busy: got %b want 0", bus.busy); end
        n_cmp++; if (done_cnt !== base) begin n_err++; $display("FAIL stray_idle_done: got %0d want %0d", done_cnt, base); end
        fill_random();
        bus.tx_busy = 1'b1;
        start_frame();
        cycles(2);
        stray_req = 1'b1;
        cycles(1);
        stray_req = 1'b0;
        cycles(2);
        n_cmp++; if (obs.size() !== 0) begin n_err++; $display("FAIL stray_load_start: got %0d want 0", obs.size()); end
        bus.tx_busy = 1'b0;
        wait_done(base, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL stray_timeout: got %b want 1", ok); end
        n_cmp++; if (obs.size() !== DEPTH) begin n_err++; $display("FAIL stray_count: got %0d want %0d", obs.size(), DEPTH); end
        for (int i = 0; i < DEPTH && i < obs.size(); i++) begin
            n_cmp++; if (obs[i] !== ref_frame[i]) begin n_err++; $display("FAIL stray_byte[%0d]: got %h want %h", i, obs[i], ref_frame[i]); end
        end
        cycles(3);
        n_cmp++; if (done_cnt - base !== 1) begin n_err++; $display("FAIL stray_done_pulses: got %0d want 1", done_cnt - base); end
    endtask

    task automatic test_final_collision();
        bit ok;
        int base;
        logic [7:0] d, keep;
        // Data write coinciding with the final tx_done must be dropped
        obs.delete();
        base = done_cnt;
        fill_random();
        keep = ref_buf[0];
        start_frame();
        for (int i = 0; i < 800 && !(bus.tx_done && ref_sent == DEPTH - 1); i++) cycles(1);
        cpu_write(0, ~keep);
        wait_done(base, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL coll_wr_timeout: got %b want 1", ok); end
        rd(0, d);
        n_cmp++; if (d !== keep) begin n_err++; $display("FAIL coll_wr_dropped: got %h want %h", d, keep); end
        cycles(2);
        // Start write coinciding with the final tx_done must be dropped
        obs.delete();
        base = done_cnt;
        start_frame();
        for (int i = 0; i < 800 && !(bus.tx_done && ref_sent == DEPTH - 1); i++) cycles(1);
        cpu_write(DEPTH, 8'h01);
        wait_done(base, ok);
        cycles(25);
        n_cmp++; if (obs.size() !== DEPTH) begin n_err++; $display("FAIL coll_start_count: got %0d want %0d", obs.size(), DEPTH); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL coll_start_dropped: got %b want 0", bus.busy); end
    endtask

    task automatic test_async_reset();
        bit ok;
        int base;
        logic [7:0] d;
        obs.delete();
        base = done_cnt;
        fill_random();
        start_frame();
        for (int i = 0; i < 200 && obs.size() < 2; i++) cycles(1);
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.tx_start !== 1'b0) begin n_err++; $display("FAIL arst_tx_start: got %b want 0", bus.tx_start); end
        n_cmp++; if (bus.tx_data !== 8'h00) begin n_err++; $display("FAIL arst_tx_data: got %h want 00", bus.tx_data); end
        n_cmp++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL arst_busy: got %b want 0", bus.busy); end
        for (int a = 0; a < 8; a++) begin
            rd(a, d);
            n_cmp++; if (d !== 8'h00) begin n_err++; $display("FAIL arst_read[%0d]: got %h want 00", a, d); end
        end
        cycles(2);
        rst_n = 1'b1;
        cycles(20);
        n_cmp++; if (done_cnt !== base) begin n_err++; $display("FAIL arst_no_done: got %0d want %0d", done_cnt, base); end
        n_cmp++; if (obs.size() !== 2) begin n_err++; $display("FAIL arst_aborted: got %0d want 2", obs.size()); end
        obs.delete();
        fill_random();
        start_frame();
        wait_done(base, ok);
        n_cmp++; if (ok !== 1'b1) begin n_err++; $display("FAIL arst_restart_timeout: got %b want 1", ok); end
        n_cmp++; if (obs.size() !== DEPTH) begin n_err++; $display("FAIL arst_restart_count: got %0d want %0d", obs.size(), DEPTH); end
        for (int i = 0; i < DEPTH && i < obs.size(); i++) begin
            n_cmp++; if (obs[i] !== ref_frame[i]) begin n_err++; $display("FAIL arst_restart_byte[%0d]: got %h want %h", i, obs[i], ref_frame[i]); end
        end
        cycles(3);
    endtask

    task automatic test_busy_tracking();
        n_cmp++; if (busy_err !== 0) begin n_err++; $display("FAIL busy_tracking: got %0d cycles off want 0", busy_err); end
    endtask

    initial begin
        bus.wr      = 1'b0;
        bus.address = '0;
        bus.w_data  = '0;
        bus.tx_busy = 1'b0;
        test_reset();
        test_frame();
        test_frozen();
        test_tx_busy_hold();
        test_stray_done();
        test_final_collision();
        test_async_reset();
        test_busy_tracking();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
